capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Trigger and frame scheduler for the ADC double-buffer capture path. Sits between the FSMC-visible configuration registers and the capture buffer. Decides when a frame starts (edge trigger, auto timeout, or single-shot arm), decimates the sample stream, and generates buffer write strobes and addresses. Swaps the ping-pong buffers only when the MCU is not holding the read lock.

## Interface
- SAMPLE_COUNT, 1024, samples per frame; power of two, ≥4
- DIV_W, 16, decimation divider width
- TO_W, 24, auto-trigger timeout counter width
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_mode  in  2  0=normal, 1=auto, 2=single, 3=stop
- cfg_edge  in  1  trigger polarity: 0=rising, 1=falling
- cfg_div  in  DIV_W  keep one tick of every cfg_div+1
- cfg_holdoff  in  16  sample ticks to wait after a swap before re-arming
- cfg_timeout  in  TO_W  auto-mode clk cycles before a forced trigger; 0=never
- cfg_arm  in  1  one-cycle pulse that arms a single-shot capture
- sample_tick  in  1  one-cycle pulse per ADC sample, already in the clk domain
- trig_in  in  1  comparator level, already synchronized
- stable  in  1  synchronized ADC-stable flag
- rd_lock  in  1  MCU read lock; swap forbidden while 1
- wr_en  out  1  buffer write strobe
- wr_addr  out  $clog2(SAMPLE_COUNT)  write address
- buf_swap  out  1  one-cycle pulse: toggle active write buffer
- frame_ready  out  1  a completed frame is readable
- auto_trig  out  1  last frame was started by timeout
- busy  out  1  state ≠ IDLE
- state_o  out  3  IDLE=0, ARMED=1, CAPTURE=2, SWAP_WAIT=3, HOLDOFF=4
- frame_cnt  out  8  completed frames, wraps at 255→0

## Operation
- IDLE:
  - In mode 0 or 1 with stable=1, go to ARMED.
  - In mode 2, go to ARMED only on cfg_arm with stable=1.
  - On entering ARMED, cfg_div, cfg_holdoff, cfg_timeout and cfg_edge are latched into shadow registers. Config changes mid-frame have no effect.
- ARMED:
  - trig_in is sampled only on sample_tick; the previous sample is kept in trig_prev.
  - Edge: rising = prev 0 → cur 1; falling = prev 1 → cur 0.
  - trig_prev is reloaded from the first tick after entering ARMED. That tick can never be an edge.
  - On an edge: go to CAPTURE, set auto_trig=0.
  - Mode 1 with shadow timeout ≠0: a timeout counter increments every clk in ARMED. When it equals the shadow timeout, go to CAPTURE with auto_trig=1. An edge in the same cycle wins (auto_trig=0).
- CAPTURE:
  - The divider count starts at 0 on entry. Each sample_tick with count==0 is a qualifying tick; the count then advances modulo shadow_div+1.
  - Qualifying ticks write addresses 0..SAMPLE_COUNT-1 in order.
  - After the write to SAMPLE_COUNT-1, go to SWAP_WAIT.
- SWAP_WAIT:
  - While rd_lock=1, hold; no samples are written.
  - When rd_lock=0: pulse buf_swap, set frame_ready=1, increment frame_cnt.
  - Next state: HOLDOFF if mode is 0 or 1, otherwise IDLE.
- HOLDOFF: count shadow_holdoff sample_ticks, then go to ARMED (new shadow latch). Holdoff 0 goes to ARMED on the next cycle.
- frame_ready clears on the rising edge of rd_lock. If a swap and a rising rd_lock edge occur in the same cycle, the swap wins and frame_ready=1.
- Abort: stable=0 in ARMED, CAPTURE or HOLDOFF goes to IDLE next cycle. The partial frame is discarded: no swap, frame_cnt unchanged.
- Stop: mode 3 forces IDLE from any state except SWAP_WAIT. SWAP_WAIT finishes its pending swap, then goes to IDLE.
- Single mode: cfg_arm is ignored outside IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, trig_prev 0.
- wr_en and wr_addr are registered: asserted one clk after the qualifying sample_tick, for exactly one cycle.
- The transition to SWAP_WAIT is in the same cycle as the final wr_en.
- buf_swap asserts the cycle after rd_lock is sampled 0 in SWAP_WAIT. frame_ready and frame_cnt update in that same cycle.
- Trigger tick to first wr_en: the first qualifying tick is the next sample_tick after entering CAPTURE, not the trigger tick itself.
- Asynchronous reset mid-frame returns to IDLE immediately. No swap is emitted.

## Test plan
- Normal mode, cfg_div=0, SAMPLE_COUNT=16, rising edge on tick 5 → wr_en on the next 16 ticks with addresses 0..15, then buf_swap=1 for 1 cycle, frame_cnt=1, frame_ready=1.
- cfg_div=3 → writes only on every 4th tick after the trigger. Address 15 is written on the 61st tick after CAPTURE entry.
- rd_lock=1 when the frame completes, held 50 cycles → state_o=3 throughout, no buf_swap. buf_swap follows 1 cycle after rd_lock falls. A later rd_lock rising edge clears frame_ready.
- Auto mode, timeout=100, trig_in constant → CAPTURE after 100 ARMED cycles with auto_trig=1. Repeat with an edge on cycle 100 → auto_trig=0.
- stable dropped at address 7 → IDLE, no buf_swap, frame_cnt unchanged. Capture restarts from address 0 after re-arm.
- Single mode: cfg_arm, one frame, then IDLE. Mode 3 during HOLDOFF → IDLE next cycle. Reset asserted mid-CAPTURE → all outputs 0.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: trigger and frame scheduler for the ADC ping-pong capture path.
// Starts frames on an edge trigger, an auto-mode timeout or a single-shot arm,
// decimates the sample stream and produces buffer write strobes/addresses.
// Buffers are swapped only while the MCU does not hold the read lock.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   cfg_mode       0=normal, 1=auto, 2=single, 3=stop
//   cfg_edge       trigger polarity (0=rising, 1=falling)
//   cfg_div        keep one sample tick of every cfg_div+1
//   cfg_holdoff    sample ticks to wait after a swap before re-arming
//   cfg_timeout    auto-mode clk cycles before a forced trigger (0=never)
//   cfg_arm        single-shot arm pulse
//   sample_tick    one pulse per ADC sample
//   trig_in        synchronized comparator level
//   stable         synchronized ADC-stable flag
//   rd_lock        MCU read lock, blocks the buffer swap
//   wr_en/wr_addr  registered buffer write strobe and address
//   buf_swap       one-cycle pulse toggling the active write buffer
//   frame_ready    a completed frame is readable
//   auto_trig      last frame was started by the timeout
//   busy           sequencer is not idle
//   state_o        IDLE=0, ARMED=1, CAPTURE=2, SWAP_WAIT=3, HOLDOFF=4
//   frame_cnt      completed frames, wrapping
module capture_sequencer #(
  parameter int unsigned SAMPLE_COUNT = 1024,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned TO_W         = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      cfg_mode,
  input  logic                            cfg_edge,
  input  logic [DIV_W-1:0]                cfg_div,
  input  logic [15:0]                     cfg_holdoff,
  input  logic [TO_W-1:0]                 cfg_timeout,
  input  logic                            cfg_arm,
  input  logic                            sample_tick,
  input  logic                            trig_in,
  input  logic                            stable,
  input  logic                            rd_lock,
  output logic                            wr_en,
  output logic [$clog2(SAMPLE_COUNT)-1:0] wr_addr,
  output logic                            buf_swap,
  output logic                            frame_ready,
  output logic                            auto_trig,
  output logic                            busy,
  output logic [2:0]                      state_o,
  output logic [7:0]                      frame_cnt
);

  localparam int unsigned ADDR_W = $clog2(SAMPLE_COUNT);
  localparam int unsigned HO_W   = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARMED     = 3'd1;
  localparam logic [2:0] S_CAPTURE   = 3'd2;
  localparam logic [2:0] S_SWAP_WAIT = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_STOP   = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLE_COUNT - 1);

  logic [2:0]        state,      state_nxt;
  logic [DIV_W-1:0]  sh_div,     sh_div_nxt;
  logic [HO_W-1:0]   sh_holdoff, sh_holdoff_nxt;
  logic [TO_W-1:0]   sh_timeout, sh_timeout_nxt;
  logic              sh_edge,    sh_edge_nxt;
  logic              trig_prev,  trig_prev_nxt;
  logic              arm_first,  arm_first_nxt;
  logic [TO_W-1:0]   to_cnt,     to_cnt_nxt;
  logic [DIV_W-1:0]  div_cnt,    div_cnt_nxt;
  logic [ADDR_W-1:0] addr_cnt,   addr_cnt_nxt;
  logic [HO_W-1:0]   hold_cnt,   hold_cnt_nxt;
  logic              rd_lock_q;

  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic              buf_swap_nxt;
  logic              frame_ready_nxt;
  logic              auto_trig_nxt;
  logic [7:0]        frame_cnt_nxt;

  logic              stop_req;
  logic              run_mode;
  logic              edge_hit;
  logic              qual_tick;
  logic              load_shadow;

  assign stop_req = (cfg_mode == MODE_STOP);
  assign run_mode = (cfg_mode == MODE_NORMAL) || (cfg_mode == MODE_AUTO);
  assign state_o  = state;

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    sh_div_nxt      = sh_div;
    sh_holdoff_nxt  = sh_holdoff;
    sh_timeout_nxt  = sh_timeout;
    sh_edge_nxt     = sh_edge;
    trig_prev_nxt   = trig_prev;
    arm_first_nxt   = arm_first;
    to_cnt_nxt      = to_cnt;
    div_cnt_nxt     = div_cnt;
    addr_cnt_nxt    = addr_cnt;
    hold_cnt_nxt    = hold_cnt;
    wr_en_nxt       = 1'b0;
    wr_addr_nxt     = wr_addr;
    buf_swap_nxt    = 1'b0;
    frame_ready_nxt = frame_ready;
    auto_trig_nxt   = auto_trig;
    frame_cnt_nxt   = frame_cnt;
    edge_hit        = 1'b0;
    qual_tick       = 1'b0;
    load_shadow     = 1'b0;

    // MCU taking the lock acknowledges the frame; a swap below overrides this
    if (rd_lock && !rd_lock_q) begin
      frame_ready_nxt = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (stable && (run_mode || ((cfg_mode == MODE_SINGLE) && cfg_arm))) begin
          load_shadow = 1'b1;
        end
      end

      S_ARMED: begin
        if (stop_req || !stable) begin
          state_nxt = S_IDLE;
        end else begin
          // The first tick after arming only seeds trig_prev
          edge_hit   = sample_tick && !arm_first &&
                       (sh_edge ? (trig_prev && !trig_in) : (!trig_prev && trig_in));
          to_cnt_nxt = to_cnt + TO_W'(1);
          if (sample_tick) begin
            trig_prev_nxt = trig_in;
            arm_first_nxt = 1'b0;
          end
          if (edge_hit) begin
            state_nxt     = S_CAPTURE;
            auto_trig_nxt = 1'b0;
            div_cnt_nxt   = '0;
            addr_cnt_nxt  = '0;
          end else if ((cfg_mode == MODE_AUTO) && (sh_timeout != '0) &&
                       (to_cnt_nxt == sh_timeout)) begin
            state_nxt     = S_CAPTURE;
            auto_trig_nxt = 1'b1;
            div_cnt_nxt   = '0;
            addr_cnt_nxt  = '0;
          end
        end
      end

      S_CAPTURE: begin
        if (stop_req || !stable) begin
          state_nxt = S_IDLE;
        end else if (sample_tick) begin
          qual_tick   = (div_cnt == '0);
          div_cnt_nxt = (div_cnt == sh_div) ? '0 : div_cnt + DIV_W'(1);
          if (qual_tick) begin
            wr_en_nxt    = 1'b1;
            wr_addr_nxt  = addr_cnt;
            addr_cnt_nxt = addr_cnt + ADDR_W'(1);
            if (addr_cnt == LAST_ADDR) begin
              state_nxt = S_SWAP_WAIT;
            end
          end
        end
      end

      S_SWAP_WAIT: begin
        // Stop and stable loss are deferred until the pending swap completes
        if (!rd_lock) begin
          buf_swap_nxt    = 1'b1;
          frame_ready_nxt = 1'b1;
          frame_cnt_nxt   = frame_cnt + 8'd1;
          if (run_mode) begin
            state_nxt    = S_HOLDOFF;
            hold_cnt_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end

      S_HOLDOFF: begin
        if (stop_req || !stable) begin
          state_nxt = S_IDLE;
        end else if (hold_cnt == sh_holdoff) begin
          load_shadow = 1'b1;
        end else if (sample_tick) begin
          hold_cnt_nxt = hold_cnt + HO_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Entering ARMED: freeze the configuration for the whole frame
    if (load_shadow) begin
      state_nxt      = S_ARMED;
      sh_div_nxt     = cfg_div;
      sh_holdoff_nxt = cfg_holdoff;
      sh_timeout_nxt = cfg_timeout;
      sh_edge_nxt    = cfg_edge;
      to_cnt_nxt     = '0;
      arm_first_nxt  = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sh_div      <= '0;
      sh_holdoff  <= '0;
      sh_timeout  <= '0;
      sh_edge     <= 1'b0;
      trig_prev   <= 1'b0;
      arm_first   <= 1'b0;
      to_cnt      <= '0;
      div_cnt     <= '0;
      addr_cnt    <= '0;
      hold_cnt    <= '0;
      rd_lock_q   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      buf_swap    <= 1'b0;
      frame_ready <= 1'b0;
      auto_trig   <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      sh_div      <= sh_div_nxt;
      sh_holdoff  <= sh_holdoff_nxt;
      sh_timeout  <= sh_timeout_nxt;
      sh_edge     <= sh_edge_nxt;
      trig_prev   <= trig_prev_nxt;
      arm_first   <= arm_first_nxt;
      to_cnt      <= to_cnt_nxt;
      div_cnt     <= div_cnt_nxt;
      addr_cnt    <= addr_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      rd_lock_q   <= rd_lock;
      wr_en       <= wr_en_nxt;
      wr_addr     <= wr_addr_nxt;
      buf_swap    <= buf_swap_nxt;
      frame_ready <= frame_ready_nxt;
      auto_trig   <= auto_trig_nxt;
      busy        <= (state_nxt != S_IDLE);
      frame_cnt   <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a 16-sample frame.
module tb_capture_sequencer;

  localparam int unsigned SC    = 16;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned TO_W  = 24;
  localparam int unsigned AW    = $clog2(SC);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       cfg_mode;
  logic             cfg_edge;
  logic [DIV_W-1:0] cfg_div;
  logic [15:0]      cfg_holdoff;
  logic [TO_W-1:0]  cfg_timeout;
  logic             cfg_arm;
  logic             sample_tick;
  logic             trig_in;
  logic             stable;
  logic             rd_lock;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             buf_swap;
  logic             frame_ready;
  logic             auto_trig;
  logic             busy;
  logic [2:0]       state_o;
  logic [7:0]       frame_cnt;

  capture_sequencer #(.SAMPLE_COUNT(SC), .DIV_W(DIV_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_edge(cfg_edge),
    .cfg_div(cfg_div), .cfg_holdoff(cfg_holdoff), .cfg_timeout(cfg_timeout),
    .cfg_arm(cfg_arm), .sample_tick(sample_tick), .trig_in(trig_in),
    .stable(stable), .rd_lock(rd_lock), .wr_en(wr_en), .wr_addr(wr_addr),
    .buf_swap(buf_swap), .frame_ready(frame_ready), .auto_trig(auto_trig),
    .busy(busy), .state_o(state_o), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       cfg_edge;
    logic       stim_fall;   // idle trigger level; active level is its inverse
    int         div;
    int         trig_tick;   // first tick carrying the active level
    int         ticks;
    int         exp_writes;
    int         exp_first;   // tick index of the address-0 write
    int         exp_last;    // tick index of the final write
    int         exp_cnt;
    int         exp_ready;
    int         exp_state;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tick_idx = 0;
  int   swap_cnt = 0;
  int   wr_log[$];
  int   tick_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are observed 1 ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    if (wr_en) begin
      wr_log.push_back(int'(wr_addr));
      tick_log.push_back(tick_idx);
    end
    if (buf_swap) swap_cnt++;
  endtask

  // One sample tick followed by one quiet cycle
  task automatic tick_with(input logic trig);
    tick_idx++;
    trig_in     = trig;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    cfg_arm     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_log.delete();
    tick_log.delete();
    swap_cnt = 0;
    tick_idx = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    int   bad;

    //            mode  cedge sfall div trig ticks wr first last cnt rdy state
    vecs[0] = '{2'd0, 1'b0, 1'b0, 0,  5,  24,  16, 6,  21,  1,  1,  4};
    vecs[1] = '{2'd0, 1'b1, 1'b1, 3,  3,  70,  16, 4,  64,  1,  1,  4};
    vecs[2] = '{2'd2, 1'b0, 1'b0, 0,  2,  20,  16, 3,  18,  1,  1,  0};
    vecs[3] = '{2'd0, 1'b0, 1'b0, 1,  2,  20,  9,  3,  19,  0,  0,  2};
    vecs[4] = '{2'd0, 1'b0, 1'b1, 0,  3,  20,  0,  0,  0,   0,  0,  1};
    vecs[5] = '{2'd0, 1'b0, 1'b0, 0,  1,  10,  0,  0,  0,   0,  0,  1};
    vecs[6] = '{2'd1, 1'b0, 1'b0, 0,  40, 45,  5,  41, 45,  0,  0,  2};

    cfg_mode = 2'd3; cfg_edge = 1'b0; cfg_div = '0; cfg_holdoff = 16'd1000;
    cfg_timeout = '0; cfg_arm = 1'b0; sample_tick = 1'b0; trig_in = 1'b0;
    stable = 1'b0; rd_lock = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset outputs",
        {wr_en, wr_addr, buf_swap, frame_ready, auto_trig, busy, state_o, frame_cnt}, '0);

    // Table-driven frame scenarios
    foreach (vecs[i]) begin
      v = vecs[i];
      cfg_mode = v.mode; cfg_edge = v.cfg_edge; cfg_div = DIV_W'(v.div);
      cfg_holdoff = 16'd1000; cfg_timeout = '0; stable = 1'b1; rd_lock = 1'b0;
      trig_in = v.stim_fall;
      do_reset();
      if (v.mode == 2'd2) begin
        cyc();
        cfg_arm = 1'b1;
        cyc();
        cfg_arm = 1'b0;
      end else begin
        cyc();
      end
      for (int t = 1; t <= v.ticks; t++) begin
        tick_with((t >= v.trig_tick) ? ~v.stim_fall : v.stim_fall);
      end
      chk($sformatf("v%0d write count", i), wr_log.size(), v.exp_writes);
      for (int k = 0; k < wr_log.size() && k < v.exp_writes; k++) begin
        chk($sformatf("v%0d addr[%0d]", i, k), wr_log[k], k);
        chk($sformatf("v%0d tick[%0d]", i, k), tick_log[k], v.exp_first + k * (v.div + 1));
      end
      if (v.exp_writes > 0 && wr_log.size() > 0)
        chk($sformatf("v%0d last write tick", i), tick_log[wr_log.size()-1], v.exp_last);
      chk($sformatf("v%0d swaps", i), swap_cnt, v.exp_cnt);
      chk($sformatf("v%0d frame_cnt", i), frame_cnt, v.exp_cnt);
      chk($sformatf("v%0d frame_ready", i), frame_ready, v.exp_ready);
      chk($sformatf("v%0d state", i), state_o, v.exp_state);
      chk($sformatf("v%0d busy", i), busy, (v.exp_state != 0) ? 1 : 0);
      chk($sformatf("v%0d auto_trig", i), auto_trig, 0);
    end

    // Read lock held while the frame completes
    cfg_mode = 2'd0; cfg_edge = 1'b0; cfg_div = '0; cfg_holdoff = 16'd1000;
    trig_in = 1'b0; stable = 1'b1; rd_lock = 1'b1;
    do_reset();
    cyc();
    repeat (2) tick_with(1'b0);
    repeat (17) tick_with(1'b1);
    bad = 0;
    for (int j = 0; j < 50; j++) begin
      sample_tick = (j % 2 == 0);
      cyc();
      if (state_o != 3'd3 || buf_swap) bad++;
    end
    sample_tick = 1'b0;
    chk("lock hold violations", bad, 0);
    chk("lock hold writes", wr_log.size(), 16);
    chk("lock hold swaps", swap_cnt, 0);
    rd_lock = 1'b0;
    cyc();
    chk("unlock buf_swap", buf_swap, 1);
    chk("unlock frame_ready", frame_ready, 1);
    chk("unlock frame_cnt", frame_cnt, 1);
    cyc();
    chk("buf_swap one cycle", buf_swap, 0);
    rd_lock = 1'b1;
    cyc();
    chk("lock edge clears ready", frame_ready, 0);
    rd_lock = 1'b0;

    // Auto mode: timeout with a constant trigger level
    cfg_mode = 2'd1; cfg_timeout = TO_W'(100); trig_in = 1'b0; stable = 1'b1;
    do_reset();
    cyc();
    n = 1;
    while (state_o == 3'd1 && n < 300) begin
      cyc();
      if (state_o == 3'd1) n++;
    end
    chk("timeout armed cycles", n, 100);
    chk("timeout state", state_o, 2);
    chk("timeout auto_trig", auto_trig, 1);
    cfg_mode = 2'd3;
    cyc();
    chk("stop from capture", state_o, 0);
    chk("auto_trig kept", auto_trig, 1);

    // Auto mode: an edge on the timeout cycle wins
    cfg_mode = 2'd1;
    cyc();
    n = 1;
    while (state_o == 3'd1 && n < 300) begin
      sample_tick = (n == 50 || n == 100);
      trig_in     = (n == 100);
      cyc();
      sample_tick = 1'b0;
      if (state_o == 3'd1) n++;
    end
    chk("edge-wins armed cycles", n, 100);
    chk("edge-wins state", state_o, 2);
    chk("edge-wins auto_trig", auto_trig, 0);

    // Abort at address 7, then a clean restart
    cfg_mode = 2'd0; cfg_timeout = '0; trig_in = 1'b0; stable = 1'b1;
    do_reset();
    cyc();
    repeat (2) tick_with(1'b0);
    repeat (9) tick_with(1'b1);
    chk("abort writes before drop", wr_log.size(), 8);
    stable = 1'b0;
    cyc();
    chk("abort state", state_o, 0);
    chk("abort swaps", swap_cnt, 0);
    chk("abort frame_cnt", frame_cnt, 0);
    stable = 1'b1;
    wr_log.delete();
    tick_log.delete();
    cyc();
    chk("rearm state", state_o, 1);
    tick_with(1'b1);
    tick_with(1'b0);
    tick_with(1'b1);
    tick_with(1'b1);
    chk("restart write count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("restart addr", wr_log[0], 0);

    // Holdoff, then stop during holdoff
    cfg_holdoff = 16'd3; trig_in = 1'b0;
    do_reset();
    cyc();
    repeat (2) tick_with(1'b0);
    repeat (17) tick_with(1'b1);
    chk("holdoff entry state", state_o, 4);
    chk("holdoff frame_cnt", frame_cnt, 1);
    repeat (2) tick_with(1'b0);
    chk("holdoff still counting", state_o, 4);
    chk("holdoff busy", busy, 1);
    cfg_mode = 2'd3;
    cyc();
    chk("stop from holdoff", state_o, 0);
    chk("stop busy", busy, 0);
    chk("stop keeps ready", frame_ready, 1);

    // Asynchronous reset in the middle of a capture
    cfg_mode = 2'd0;
    cyc();
    tick_with(1'b0);
    tick_with(1'b0);
    repeat (5) tick_with(1'b1);
    chk("pre-reset addr", wr_addr, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs",
        {wr_en, wr_addr, buf_swap, frame_ready, auto_trig, busy, state_o, frame_cnt}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
